// File: rtl/rms_pkg.sv
// Shared widths and sqrt-engine state encoding for the windowed RMS front end.
package rms_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned LOG2_WIN_DEF = 4;
  localparam int unsigned SQ_W         = 2 * DATA_W_DEF;
  localparam int unsigned ACC_W        = SQ_W + LOG2_WIN_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

endpackage

// File: rtl/rms_calculator_if.sv
// Sample stream in, RMS result and status out.
interface rms_calculator_if
  import rms_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OUT_W  = DATA_W_DEF
);

  logic                     clear;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic        [OUT_W-1:0]  rms_val;
  logic                     rms_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output clear, sample_in, sample_valid,
    input  rms_val, rms_valid, busy, overrun
  );

  modport slave (
    input  clear, sample_in, sample_valid,
    output rms_val, rms_valid, busy, overrun
  );

endinterface

// File: rtl/isqrt_seq.sv
// Restoring bit-serial integer square root, one result bit per clock, MSB first.
module isqrt_seq
  import rms_pkg::*;
#(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned RAD_W = 2 * OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [RAD_W-1:0] radicand,
  output logic [OUT_W-1:0] root,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(OUT_W);
  localparam int unsigned REM_W = OUT_W + 1;
  localparam int unsigned TRY_W = OUT_W + 3;

  sqrt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] work_q, work_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [TRY_W-1:0] rem_sh_c, trial_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Remainder never exceeds 2*root, so REM_W bits hold it after every step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    work_d   = work_q;
    rad_d    = rad_q;
    root_d   = root_q;
    done_d   = 1'b0;
    rem_sh_c = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial_c  = TRY_W'({work_q, 2'b01});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          rad_d   = radicand;
          rem_d   = '0;
          work_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        rad_d = {rad_q[RAD_W-3:0], 2'b00};
        if (rem_sh_c >= trial_c) begin
          rem_d  = REM_W'(rem_sh_c - trial_c);
          work_d = {work_q[OUT_W-2:0], 1'b1};
        end else begin
          rem_d  = REM_W'(rem_sh_c);
          work_d = {work_q[OUT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_W - 1)) state_d = DONE;
      end
      DONE: begin
        root_d  = work_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  assign root = root_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/rms_calculator.sv
// Windowed RMS: square, accumulate 2**LOG2_WIN accepted samples, then sequential sqrt of the mean.
module rms_calculator
  import rms_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOG2_WIN = LOG2_WIN_DEF,
  parameter int unsigned OUT_W    = DATA_W
) (
  input logic             clk,
  input logic             rst,
  rms_calculator_if.slave bus
);

  localparam int unsigned SQ_BITS  = 2 * DATA_W;
  localparam int unsigned ACC_BITS = SQ_BITS + LOG2_WIN;

  logic signed [SQ_BITS-1:0]  sample_ext_c;
  logic signed [SQ_BITS-1:0]  product_c;
  logic        [SQ_BITS-1:0]  square_c;
  logic        [ACC_BITS-1:0] acc_sum_c;
  logic        [SQ_BITS-1:0]  mean_c;
  logic                       last_c;
  logic                       start_c;
  logic                       eng_busy;

  logic [ACC_BITS-1:0] acc_q;
  logic [LOG2_WIN-1:0] cnt_q;
  logic                overrun_q;

  assign sample_ext_c = SQ_BITS'(bus.sample_in);
  assign product_c    = sample_ext_c * sample_ext_c;
  assign square_c     = product_c;
  assign acc_sum_c    = acc_q + ACC_BITS'(square_c);
  assign mean_c       = SQ_BITS'(acc_sum_c >> LOG2_WIN);
  assign last_c       = bus.sample_valid && (&cnt_q);
  assign start_c      = last_c && !eng_busy && !bus.clear;

  // A window finishing while the engine is occupied is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else if (bus.clear) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else if (bus.sample_valid) begin
      if (last_c) begin
        acc_q <= '0;
        cnt_q <= '0;
        if (eng_busy) overrun_q <= 1'b1;
      end else begin
        acc_q <= acc_sum_c;
        cnt_q <= cnt_q + LOG2_WIN'(1);
      end
    end
  end

  isqrt_seq #(
    .OUT_W (OUT_W),
    .RAD_W (SQ_BITS)
  ) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .abort    (bus.clear),
    .radicand (mean_c),
    .root     (bus.rms_val),
    .done     (bus.rms_valid),
    .busy     (eng_busy)
  );

  assign bus.busy    = eng_busy;
  assign bus.overrun = overrun_q;

endmodule
